// File: rtl/pixel_plane_fetch.sv
// Framebuffer prefetch and bit-plane extraction feeding the panel's six serial colour lines.
// One wide read per column returns top and bottom pixels; a single prefetch slot hides read latency.
module pixel_plane_fetch #(
  parameter int NUM_COLS = 64,
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 6,
  parameter int RD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         mem_rd,
  input  logic [ROW_BITS-1:0]          row_sel,
  input  logic [7:0]                   col_counter,
  input  logic [2:0]                   bit_plane,
  output logic                         fb_rd_en,
  output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
  input  logic [23:0]                  fb_rdata,
  output logic                         R0,
  output logic                         G0,
  output logic                         B0,
  output logic                         R1,
  output logic                         G1,
  output logic                         B1,
  output logic                         data_valid,
  output logic                         underrun
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t                state, state_d;
  logic                  mem_rd_q;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [1:0]            gen_q, gen_d;
  logic                  col1_q, col1_d;
  logic [7:0]            cur_col_q, cur_col_d;
  logic                  nxt_vld_q, nxt_vld_d;
  logic [23:0]           nxt_pix_q, nxt_pix_d;
  logic [5:0]            rgb_q, rgb_d;
  logic                  dv_d, ur_d;
  logic                  issue;
  logic [COL_BITS-1:0]   issue_col;
  logic                  trk_vld_p0, trk_vld_p1;
  logic [COL_BITS-1:0]   trk_col_p0, trk_col_p1;
  logic [1:0]            trk_gen_p0, trk_gen_p1;
  logic                  ret_hit;
  logic [7:0]            ret_col;
  logic [7:0]            cur_nxt, nxt_col;
  logic                  adv;

  function automatic logic [5:0] plane_bits(input logic [23:0] px, input logic [2:0] plane);
    logic [3:0] rt, gt, bt, rb, gb, bb;
    {rt, gt, bt, rb, gb, bb} = px;
    if (plane[2]) plane_bits = 6'd0;
    else plane_bits = {rt[plane[1:0]], gt[plane[1:0]], bt[plane[1:0]],
                       rb[plane[1:0]], gb[plane[1:0]], bb[plane[1:0]]};
  endfunction

  // A return is only trusted if it belongs to the current session (generation tag).
  assign ret_hit = ((RD_LAT == 2) ? trk_vld_p1 : trk_vld_p0) &&
                   (((RD_LAT == 2) ? trk_gen_p1 : trk_gen_p0) == gen_q) && (state != IDLE);
  assign ret_col = 8'((RD_LAT == 2) ? trk_col_p1 : trk_col_p0);
  assign cur_nxt = cur_col_q + 8'd1;
  assign nxt_col = col_counter + 8'd1;
  assign adv     = (state == STREAM) && (col_counter == cur_nxt) && (col_counter < 8'(NUM_COLS));

  always_comb begin
    state_d   = state;
    row_d     = row_q;
    gen_d     = gen_q;
    col1_d    = col1_q;
    cur_col_d = cur_col_q;
    nxt_vld_d = nxt_vld_q;
    nxt_pix_d = nxt_pix_q;
    rgb_d     = rgb_q;
    dv_d      = data_valid;
    ur_d      = underrun;
    issue     = 1'b0;
    issue_col = '0;
    if (!mem_rd) begin
      state_d   = IDLE;
      dv_d      = 1'b0;
      rgb_d     = 6'd0;
      nxt_vld_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_rd_q) begin
            row_d     = row_sel;
            gen_d     = gen_q + 2'd1;
            col1_d    = 1'b0;
            nxt_vld_d = 1'b0;
            issue     = 1'b1;
            state_d   = PRIME;
          end
        end
        PRIME: begin
          if (!col1_q) begin
            issue     = 1'b1;
            issue_col = COL_BITS'(1);
            col1_d    = 1'b1;
          end
          if (ret_hit && ret_col == 8'd0) begin
            rgb_d     = plane_bits(fb_rdata, bit_plane);
            dv_d      = 1'b1;
            cur_col_d = 8'd0;
            state_d   = STREAM;
          end
        end
        STREAM: begin
          if (adv) begin
            cur_col_d = col_counter;
            if (nxt_vld_q) begin
              rgb_d     = plane_bits(nxt_pix_q, bit_plane);
              nxt_vld_d = ret_hit && (ret_col == nxt_col);
              nxt_pix_d = fb_rdata;
            end else if (ret_hit && ret_col == col_counter) begin
              // data landing on the advance edge goes straight to the outputs
              rgb_d = plane_bits(fb_rdata, bit_plane);
            end else begin
              rgb_d = 6'd0;
              ur_d  = 1'b1;
            end
            if (nxt_col < 8'(NUM_COLS)) begin
              issue     = 1'b1;
              issue_col = nxt_col[COL_BITS-1:0];
            end
          end else if (ret_hit && ret_col == cur_nxt) begin
            nxt_vld_d = 1'b1;
            nxt_pix_d = fb_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_rd_q   <= 1'b0;
      row_q      <= '0;
      gen_q      <= 2'd0;
      col1_q     <= 1'b0;
      cur_col_q  <= 8'd0;
      nxt_vld_q  <= 1'b0;
      rgb_q      <= 6'd0;
      data_valid <= 1'b0;
      underrun   <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      trk_vld_p0 <= 1'b0;
      trk_col_p0 <= '0;
      trk_gen_p0 <= 2'd0;
      trk_vld_p1 <= 1'b0;
      trk_col_p1 <= '0;
      trk_gen_p1 <= 2'd0;
    end else if (clk_en) begin
      state      <= state_d;
      mem_rd_q   <= mem_rd;
      row_q      <= row_d;
      gen_q      <= gen_d;
      col1_q     <= col1_d;
      cur_col_q  <= cur_col_d;
      nxt_vld_q  <= nxt_vld_d;
      rgb_q      <= rgb_d;
      data_valid <= dv_d;
      underrun   <= ur_d;
      fb_rd_en   <= issue;
      if (issue) fb_addr <= {row_d, issue_col};
      // read-tracking pipeline: p0 = issued this edge, p1 = one enabled cycle older
      trk_vld_p0 <= issue;
      trk_col_p0 <= issue_col;
      trk_gen_p0 <= gen_d;
      trk_vld_p1 <= trk_vld_p0;
      trk_col_p1 <= trk_col_p0;
      trk_gen_p1 <= trk_gen_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) nxt_pix_q <= nxt_pix_d;
  end

  assign {R0, G0, B0, R1, G1, B1} = rgb_q;

endmodule
